// File: rtl/fm_qarctan_ctrl.sv
// Quadrature-arctangent front end: turns one I/Q pair into a fixed-point phase
// angle, using an external sequential divider for the qarctan ratio.
module fm_qarctan_ctrl #(
   parameter int DATA_WIDTH     = 16,
   parameter int BITS           = 10,
   parameter int DIVIDEND_WIDTH = 64,
   parameter int DIVISOR_WIDTH  = 32,
   parameter int QUAD1          = 804,
   parameter int QUAD3          = 2412
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     x,
   input  logic [DATA_WIDTH-1:0]     y,
   output logic                      div_valid_in,
   output logic [DIVIDEND_WIDTH-1:0] div_dividend,
   output logic [DIVISOR_WIDTH-1:0]  div_divisor,
   input  logic [DIVIDEND_WIDTH-1:0] div_quotient,
   input  logic                      div_valid_out,
   input  logic                      div_overflow,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     angle,
   output logic                      err
);

   localparam int DW  = DATA_WIDTH;
   localparam int AW  = DATA_WIDTH + 1;
   localparam int NW  = DIVIDEND_WIDTH;
   localparam int VW  = DIVISOR_WIDTH;
   localparam int PW  = DIVIDEND_WIDTH + DATA_WIDTH + 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PREP  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_SCALE = 3'd4,
      S_OUT   = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [DW-1:0]          x_q, x_d;
   logic [DW-1:0]          y_q, y_d;
   logic [NW-1:0]          dividend_q, dividend_d;
   logic [VW-1:0]          divisor_q, divisor_d;
   logic                   neg_num_q, neg_num_d;
   logic                   neg_y_q, neg_y_d;
   logic                   base3_q, base3_d;
   logic signed [NW:0]     r_q, r_d;
   logic                   err_c_q, err_c_d;
   logic [DW-1:0]          angle_q, angle_d;
   logic                   err_q, err_d;
   logic                   out_valid_q, out_valid_d;
   logic                   div_valid_q, div_valid_d;

   logic [AW-1:0]          y_ext_s;
   logic [AW-1:0]          abs_y_s;
   logic signed [NW-1:0]   x_nw_s, ay_nw_s, diff_s, num_s;
   logic [NW-1:0]          mag_s;
   logic [VW-1:0]          x_vw_s, ay_vw_s, den_s;
   logic [NW:0]            quot_ext_s;
   logic signed [PW-1:0]   r_pw_s, quad1_s, base_s, prod_s;
   logic signed [DW-1:0]   a_s, angle_c_s;

   // Operand formation: widened |y|+1 keeps the divisor non-zero and the corners overflow-free.
   always_comb begin
      y_ext_s  = {y_q[DW-1], y_q};
      abs_y_s  = (y_q[DW-1] ? (AW'(0) - y_ext_s) : y_ext_s) + AW'(1);
      x_nw_s   = {{(NW-DW){x_q[DW-1]}}, x_q};
      ay_nw_s  = {{(NW-AW){1'b0}}, abs_y_s};
      x_vw_s   = {{(VW-DW){x_q[DW-1]}}, x_q};
      ay_vw_s  = {{(VW-AW){1'b0}}, abs_y_s};
      if (x_q[DW-1]) begin
         diff_s = x_nw_s + ay_nw_s;
         den_s  = ay_vw_s - x_vw_s;
      end else begin
         diff_s = x_nw_s - ay_nw_s;
         den_s  = x_vw_s + ay_vw_s;
      end
      num_s = diff_s <<< BITS;
      if (num_s[NW-1]) begin
         mag_s = NW'(0) - num_s;
      end else begin
         mag_s = num_s;
      end
   end

   // Angle scaling: floor shift of the full-width product, then fold in the sign of y.
   always_comb begin
      quot_ext_s = {1'b0, div_quotient};
      r_pw_s     = {{(PW-NW-1){r_q[NW]}}, r_q};
      quad1_s    = PW'(QUAD1);
      base_s     = base3_q ? PW'(QUAD3) : PW'(QUAD1);
      prod_s     = quad1_s * r_pw_s;
      a_s        = DW'(base_s - (prod_s >>> BITS));
      if (neg_y_q) begin
         angle_c_s = -a_s;
      end else begin
         angle_c_s = a_s;
      end
   end

   // Next-state and register updates for the one-sample-in-flight controller.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      neg_num_d   = neg_num_q;
      neg_y_d     = neg_y_q;
      base3_d     = base3_q;
      r_d         = r_q;
      err_c_d     = err_c_q;
      angle_d     = angle_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      div_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               x_d     = x;
               y_d     = y;
               state_d = S_PREP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PREP: begin
            dividend_d  = mag_s;
            divisor_d   = den_s;
            neg_num_d   = num_s[NW-1];
            neg_y_d     = y_q[DW-1];
            base3_d     = x_q[DW-1];
            div_valid_d = 1'b1;
            state_d     = S_ISSUE;
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (div_valid_out) begin
               r_d     = neg_num_q ? ((NW+1)'(0) - quot_ext_s) : quot_ext_s;
               err_c_d = div_overflow;
               state_d = S_SCALE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_SCALE: begin
            angle_d     = err_c_q ? DW'(0) : angle_c_s;
            err_d       = err_c_q;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               state_d = S_OUT;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         dividend_q  <= '0;
         divisor_q   <= '0;
         neg_num_q   <= 1'b0;
         neg_y_q     <= 1'b0;
         base3_q     <= 1'b0;
         r_q         <= '0;
         err_c_q     <= 1'b0;
         angle_q     <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         div_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         neg_num_q   <= neg_num_d;
         neg_y_q     <= neg_y_d;
         base3_q     <= base3_d;
         r_q         <= r_d;
         err_c_q     <= err_c_d;
         angle_q     <= angle_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         div_valid_q <= div_valid_d;
      end
   end

   assign in_ready     = (state_q == S_IDLE);
   assign div_valid_in = div_valid_q;
   assign div_dividend = dividend_q;
   assign div_divisor  = divisor_q;
   assign out_valid    = out_valid_q;
   assign angle        = angle_q;
   assign err          = err_q;

endmodule

// File: tb/tb_fm_qarctan_ctrl.sv
// Self-checking bench for fm_qarctan_ctrl: behavioural divider and angle model,
// directed test-plan vectors plus randomized samples.
module tb_fm_qarctan_ctrl;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [15:0]  x, y;
   logic         div_valid_in;
   logic [63:0]  div_dividend;
   logic [31:0]  div_divisor;
   logic [63:0]  div_quotient;
   logic         div_valid_out;
   logic         div_overflow;
   logic         out_valid;
   logic         out_ready;
   logic [15:0]  angle;
   logic         err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fm_qarctan_ctrl dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .div_valid_in(div_valid_in), .div_dividend(div_dividend),
      .div_divisor(div_divisor), .div_quotient(div_quotient),
      .div_valid_out(div_valid_out), .div_overflow(div_overflow),
      .out_valid(out_valid), .out_ready(out_ready), .angle(angle), .err(err)
   );

   // Reference: qarctan with plain integer arithmetic
   function automatic void model(input int xi, input int yi,
                                 output longint dvd, output longint dvs, output longint ang);
      longint ay, num, den, base, q, r, prod, fl, a;
      ay = ((yi < 0) ? -yi : yi) + 1;
      if (xi >= 0) begin
         num = (xi - ay) * 1024; den = xi + ay; base = 804;
      end else begin
         num = (xi + ay) * 1024; den = ay - xi; base = 2412;
      end
      dvd  = (num < 0) ? -num : num;
      dvs  = den;
      q    = dvd / den;
      r    = (num < 0) ? -q : q;
      prod = 804 * r;
      if (prod < 0 && (prod % 1024) != 0) fl = prod / 1024 - 1;
      else fl = prod / 1024;
      a    = base - fl;
      ang  = (yi < 0) ? -a : a;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_sample(input int xi, input int yi, input bit ovf,
                             input int hold, input bit early, input string tag);
      longint e_dvd, e_dvs, e_ang;
      logic [31:0] e_dvs32;
      logic [15:0] e_ang16;
      logic [15:0] ang_held;
      int waitc;
      model(xi, yi, e_dvd, e_dvs, e_ang);
      e_dvs32 = e_dvs[31:0];
      e_ang16 = ovf ? 16'd0 : e_ang[15:0];
      waitc = 0;
      while (in_ready !== 1'b1 && waitc < 50) begin
         tick();
         waitc++;
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL %s in_ready_wait got=%b want=1", tag, in_ready);
      end
      x = xi[15:0]; y = yi[15:0]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; x = 16'($urandom); y = 16'($urandom);
      total++;
      if (div_valid_in !== 1'b0 || in_ready !== 1'b0) begin
         bad++; $display("FAIL %s prep_cycle div_valid_in=%b in_ready=%b want 0/0", tag, div_valid_in, in_ready);
      end
      tick();
      total++;
      if (div_valid_in !== 1'b1) begin
         bad++; $display("FAIL %s issue_pulse got=%b want=1", tag, div_valid_in);
      end
      total++;
      if (div_dividend !== e_dvd || div_divisor !== e_dvs32) begin
         bad++; $display("FAIL %s operands got=%0d/%0d want=%0d/%0d", tag, div_dividend, div_divisor, e_dvd, e_dvs32);
      end
      tick();
      total++;
      if (div_valid_in !== 1'b0) begin
         bad++; $display("FAIL %s issue_single got=%b want=0", tag, div_valid_in);
      end
      repeat ($urandom_range(0, 4)) tick();
      div_quotient  = ovf ? {$urandom, $urandom} : 64'(e_dvd / e_dvs);
      div_overflow  = ovf;
      div_valid_out = 1'b1;
      if (early) out_ready = 1'b1;
      tick();
      div_valid_out = 1'b0; div_overflow = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL %s scale_cycle out_valid=%b want=0", tag, out_valid);
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || angle !== e_ang16 || err !== ovf || in_ready !== 1'b0) begin
         bad++; $display("FAIL %s result got v=%b angle=%0d err=%b rdy=%b want v=1 angle=%0d err=%b rdy=0",
                         tag, out_valid, $signed(angle), err, in_ready, $signed(e_ang16), ovf);
      end
      ang_held = e_ang16;
      if (!early) begin
         for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; x = 16'($urandom); y = 16'($urandom);
            tick();
            total++;
            if (out_valid !== 1'b1 || angle !== ang_held || in_ready !== 1'b0) begin
               bad++; $display("FAIL %s hold%0d got v=%b angle=%0d rdy=%b want v=1 angle=%0d rdy=0",
                               tag, i, out_valid, $signed(angle), in_ready, $signed(ang_held));
            end
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      tick();
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL %s handshake got v=%b rdy=%b want v=0 rdy=1", tag, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      total++;
      if (out_valid !== 1'b0 || angle !== 16'd0 || err !== 1'b0 || div_valid_in !== 1'b0 ||
          div_dividend !== 64'd0 || div_divisor !== 32'd0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_state v=%b angle=%0d err=%b dvi=%b dvd=%0d dvs=%0d rdy=%b",
                         out_valid, angle, err, div_valid_in, div_dividend, div_divisor, in_ready);
      end
   endtask

   task automatic test_plan_vectors();
      run_sample(1024, 0, 1'b0, 0, 1'b0, "x1024_y0");
      run_sample(0, 1024, 1'b0, 1, 1'b0, "x0_y1024");
      run_sample(0, -1024, 1'b0, 0, 1'b0, "x0_yn1024");
      run_sample(-1024, 0, 1'b0, 2, 1'b0, "xn1024_y0");
   endtask

   task automatic test_hold();
      run_sample(724, 724, 1'b0, 5, 1'b0, "hold_724");
   endtask

   task automatic test_overflow();
      run_sample(300, -200, 1'b1, 1, 1'b0, "ovf");
      run_sample(1024, 0, 1'b0, 0, 1'b0, "ovf_clear");
   endtask

   task automatic test_boundaries();
      run_sample(0, 0, 1'b0, 0, 1'b0, "zero");
      run_sample(-32768, -32768, 1'b0, 0, 1'b0, "min_min");
      run_sample(32767, -32768, 1'b0, 0, 1'b0, "max_min");
      run_sample(-32768, 32767, 1'b0, 0, 1'b0, "min_max");
      run_sample(-32768, 0, 1'b0, 0, 1'b1, "early_ready");
   endtask

   task automatic test_reset_midop();
      x = 16'd1024; y = 16'd0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || div_valid_in !== 1'b0 || div_dividend !== 64'd0) begin
         bad++; $display("FAIL midop_reset v=%b rdy=%b dvi=%b dvd=%0d", out_valid, in_ready, div_valid_in, div_dividend);
      end
      tick();
      reset = 1'b0;
      tick();
      div_quotient = 64'd1022; div_valid_out = 1'b1;
      tick();
      div_valid_out = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL midop_stray%0d v=%b rdy=%b want v=0 rdy=1", i, out_valid, in_ready);
         end
      end
      run_sample(1024, 0, 1'b0, 0, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      logic signed [15:0] rx, ry;
      for (int n = 0; n < 30; n++) begin
         rx = 16'($urandom);
         ry = 16'($urandom);
         if (n % 3 == 0) begin
            rx = 16'($signed(10'($urandom)));
            ry = 16'($signed(10'($urandom)));
         end
         run_sample(int'(rx), int'(ry), 1'b0, $urandom_range(0, 2), 1'($urandom), "random");
      end
   endtask

   task automatic test_back_to_back();
      run_sample(100, 50, 1'b0, 0, 1'b1, "b2b_a");
      run_sample(-100, -50, 1'b0, 0, 1'b1, "b2b_b");
      run_sample(5, -3000, 1'b0, 0, 1'b0, "b2b_c");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; x = 16'd0; y = 16'd0;
      div_quotient = 64'd0; div_valid_out = 1'b0; div_overflow = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      test_reset();
      reset = 1'b0;
      tick();
      test_reset();
      test_plan_vectors();
      test_hold();
      test_overflow();
      test_boundaries();
      test_reset_midop();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
